// File: rtl/pc_gen.sv
// pc_gen: program counter / next-PC generator with branch, jump, jr, exception and eret handling.
// Define PC_DELAY_SLOT_EN to build with a MIPS branch-delay slot (redirect lands one fetch late).
module pc_gen #(
  parameter int unsigned ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic [1:0]        redirect_sel,
  input  logic              br_taken,
  input  logic [15:0]       br_imm,
  input  logic [25:0]       j_index,
  input  logic [ADDR_W-1:0] jr_addr,
  input  logic              exc_req,
  input  logic              eret,
  input  logic [ADDR_W-1:0] epc,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] pc_plus8,
  output logic              adel,
  output logic              slot_pending
);

  localparam logic [ADDR_W-1:0] RESET_V = RESET_PC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] EXC_V   = EXC_VEC[ADDR_W-1:0];

  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] br_offset;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] redirect_target;
  logic              redirect_active;

  assign pc_plus4  = pc + ADDR_W'(4);
  assign pc_plus8  = pc + ADDR_W'(8);
  assign adel      = |pc[1:0];
  assign br_offset = {{(ADDR_W-18){br_imm[15]}}, br_imm, 2'b00};
  assign br_target = pc_plus4 + br_offset;

  // A 28-bit PC has no region bits above the jump index to carry over.
  generate
    if (ADDR_W > 28) begin : g_jump_region
      assign jump_target = {pc_plus4[ADDR_W-1:28], j_index, 2'b00};
    end else begin : g_jump_flat
      assign jump_target = {j_index, 2'b00};
    end
  endgenerate

  always_comb begin
    redirect_active = 1'b0;
    redirect_target = pc_plus4;
    case (redirect_sel)
      2'b01: begin
        redirect_active = br_taken;
        redirect_target = br_target;
      end
      2'b10: begin
        redirect_active = 1'b1;
        redirect_target = jump_target;
      end
      2'b11: begin
        redirect_active = 1'b1;
        redirect_target = jr_addr;
      end
      default: ;
    endcase
  end

`ifdef PC_DELAY_SLOT_EN
  typedef enum logic {SEQ, SLOT} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] pending, pending_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SEQ;
      pending <= '0;
      pc      <= RESET_V;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      pc      <= pc_next;
    end
  end

  // In SLOT the queued target wins over whatever redirect the slot instruction presents.
  always_comb begin
    pc_next      = pc_plus4;
    state_next   = state;
    pending_next = pending;
    if (exc_req) begin
      pc_next    = EXC_V;
      state_next = SEQ;
    end else if (eret) begin
      pc_next    = epc;
      state_next = SEQ;
    end else if (stall) begin
      pc_next = pc;
    end else if (state == SLOT) begin
      pc_next    = pending;
      state_next = SEQ;
    end else if (redirect_active) begin
      pending_next = redirect_target;
      state_next   = SLOT;
    end
  end

  assign slot_pending = (state == SLOT);
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_V;
    end else begin
      pc <= pc_next;
    end
  end

  always_comb begin
    pc_next = pc_plus4;
    if (exc_req) begin
      pc_next = EXC_V;
    end else if (eret) begin
      pc_next = epc;
    end else if (stall) begin
      pc_next = pc;
    end else if (redirect_active) begin
      pc_next = redirect_target;
    end
  end

  assign slot_pending = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard testbench for pc_gen; expectations cover both builds via PC_DELAY_SLOT_EN.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n, w_rst_n;
  logic        stall, br_taken, exc_req, eret;
  logic [1:0]  redirect_sel;
  logic [15:0] br_imm;
  logic [25:0] j_index;
  logic [31:0] jr_addr, epc;
  logic [31:0] pc, pc_plus4, pc_plus8;
  logic        adel, slot_pending;
  logic [27:0] w_jr_addr, w_epc, w_pc, w_pc_plus4, w_pc_plus8;
  logic        w_adel, w_slot_pending;

  typedef struct {
    logic [31:0] pc;
    logic        pend;
  } exp_t;

  exp_t sb[$];
  int   tests_run = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_sel(redirect_sel),
    .br_taken(br_taken), .br_imm(br_imm), .j_index(j_index), .jr_addr(jr_addr),
    .exc_req(exc_req), .eret(eret), .epc(epc), .pc(pc), .pc_plus4(pc_plus4),
    .pc_plus8(pc_plus8), .adel(adel), .slot_pending(slot_pending)
  );

  // Narrow instance whose reset vector sits one word below the 28-bit wrap point.
  pc_gen #(.ADDR_W(28), .RESET_PC(32'h0FFF_FFFC)) dut_w (
    .clk(clk), .rst_n(w_rst_n), .stall(stall), .redirect_sel(redirect_sel),
    .br_taken(br_taken), .br_imm(br_imm), .j_index(j_index), .jr_addr(w_jr_addr),
    .exc_req(exc_req), .eret(eret), .epc(w_epc), .pc(w_pc), .pc_plus4(w_pc_plus4),
    .pc_plus8(w_pc_plus8), .adel(w_adel), .slot_pending(w_slot_pending)
  );

  task automatic idle();
    stall = 0; redirect_sel = 2'b00; br_taken = 0; br_imm = '0; j_index = '0;
    jr_addr = '0; exc_req = 0; eret = 0; epc = '0;
  endtask

  task automatic step(input logic [31:0] exp_pc, input logic exp_pend);
    exp_t e;
    e.pc = exp_pc;
    e.pend = exp_pend;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    tests_run += 4;
    if (pc !== 32'h3000) begin failed++; $display("[TB] FAIL reset_pc: got %h want 3000", pc); end
    if (pc_plus4 !== 32'h3004) begin failed++; $display("[TB] FAIL reset_plus4: got %h want 3004", pc_plus4); end
    if (adel !== 1'b0) begin failed++; $display("[TB] FAIL reset_adel: got %b want 0", adel); end
    if (slot_pending !== 1'b0) begin failed++; $display("[TB] FAIL reset_pend: got %b want 0", slot_pending); end
    for (int i = 1; i <= 2; i++) begin
      step(32'h3000 + 32'(4 * i), 1'b0);
      e = sb.pop_front(); tests_run++;
      if (pc !== e.pc) begin failed++; $display("[TB] FAIL reset_run: got %h want %h", pc, e.pc); end
    end
    #1 rst_n = 0;
    #1 tests_run++;
    if (pc !== 32'h3000) begin failed++; $display("[TB] FAIL async_reset: got %h want 3000", pc); end
    #1 rst_n = 1;
  endtask

  task automatic test_sequential();
    exp_t e;
    for (int i = 1; i <= 3; i++) begin
      step(32'h3000 + 32'(4 * i), 1'b0);
      e = sb.pop_front(); tests_run++;
      if (pc !== e.pc || slot_pending !== e.pend) begin
        failed++; $display("[TB] FAIL seq: pc=%h pend=%b want %h/%b", pc, slot_pending, e.pc, e.pend);
      end
    end
    tests_run++;
    if (pc_plus8 !== 32'h3014) begin failed++; $display("[TB] FAIL plus8: got %h want 3014", pc_plus8); end
  endtask

  task automatic test_branch();
    exp_t e;
    step(32'h3010, 1'b0);
    e = sb.pop_front(); tests_run++;
    if (pc !== e.pc) begin failed++; $display("[TB] FAIL br_setup: got %h want %h", pc, e.pc); end
    redirect_sel = 2'b01; br_taken = 1; br_imm = 16'hFFFC;
`ifdef PC_DELAY_SLOT_EN
    step(32'h3014, 1'b1);
    e = sb.pop_front(); tests_run++;
    if (pc !== e.pc || slot_pending !== e.pend) begin
      failed++; $display("[TB] FAIL br_slot: pc=%h pend=%b want %h/%b", pc, slot_pending, e.pc, e.pend);
    end
    idle();
`endif
    step(32'h3004, 1'b0);
    e = sb.pop_front(); tests_run++;
    if (pc !== e.pc || slot_pending !== e.pend) begin
      failed++; $display("[TB] FAIL br_taken: pc=%h pend=%b want %h/%b", pc, slot_pending, e.pc, e.pend);
    end
    idle();
    for (int i = 2; i <= 4; i++) begin
      step(32'h3000 + 32'(4 * i), 1'b0);
      e = sb.pop_front(); tests_run++;
      if (pc !== e.pc) begin failed++; $display("[TB] FAIL br_walk: got %h want %h", pc, e.pc); end
    end
    redirect_sel = 2'b01; br_taken = 0; br_imm = 16'hFFFC;
    step(32'h3014, 1'b0);
    e = sb.pop_front(); tests_run++;
    if (pc !== e.pc || slot_pending !== e.pend) begin
      failed++; $display("[TB] FAIL br_not_taken: pc=%h pend=%b want %h/%b", pc, slot_pending, e.pc, e.pend);
    end
    idle();
  endtask

  task automatic test_jump();
    exp_t e;
    #2 rst_n = 0;
    #1 rst_n = 1;
    tests_run++;
    if (pc !== 32'h3000) begin failed++; $display("[TB] FAIL jump_reset: got %h want 3000", pc); end
    redirect_sel = 2'b10; j_index = 26'h0000C10;
`ifdef PC_DELAY_SLOT_EN
    step(32'h3004, 1'b1);
    e = sb.pop_front(); tests_run++;
    if (pc !== e.pc || slot_pending !== e.pend) begin
      failed++; $display("[TB] FAIL jump_slot: pc=%h pend=%b want %h/%b", pc, slot_pending, e.pc, e.pend);
    end
    idle();
`endif
    step(32'h3040, 1'b0);
    e = sb.pop_front(); tests_run++;
    if (pc !== e.pc || slot_pending !== e.pend) begin
      failed++; $display("[TB] FAIL jump: pc=%h pend=%b want %h/%b", pc, slot_pending, e.pc, e.pend);
    end
    redirect_sel = 2'b11; jr_addr = 32'h3102;
`ifdef PC_DELAY_SLOT_EN
    step(32'h3044, 1'b1);
    e = sb.pop_front(); tests_run++;
    if (pc !== e.pc || slot_pending !== e.pend) begin
      failed++; $display("[TB] FAIL jr_slot: pc=%h pend=%b want %h/%b", pc, slot_pending, e.pc, e.pend);
    end
    idle();
`endif
    step(32'h3102, 1'b0);
    e = sb.pop_front(); tests_run += 2;
    if (pc !== e.pc) begin failed++; $display("[TB] FAIL jr: got %h want %h", pc, e.pc); end
    if (adel !== 1'b1) begin failed++; $display("[TB] FAIL jr_adel: got %b want 1", adel); end
    idle();
  endtask

  task automatic test_stall();
    exp_t e;
    #2 rst_n = 0;
    #1 rst_n = 1;
    redirect_sel = 2'b01; br_taken = 1; br_imm = 16'h0004;
`ifdef PC_DELAY_SLOT_EN
    step(32'h3004, 1'b1);
    e = sb.pop_front(); tests_run++;
    if (pc !== e.pc || slot_pending !== e.pend) begin
      failed++; $display("[TB] FAIL stall_queue: pc=%h pend=%b want %h/%b", pc, slot_pending, e.pc, e.pend);
    end
    stall = 1; redirect_sel = 2'b10; j_index = 26'h0000400;
    for (int i = 0; i < 2; i++) begin
      step(32'h3004, 1'b1);
      e = sb.pop_front(); tests_run++;
      if (pc !== e.pc || slot_pending !== e.pend) begin
        failed++; $display("[TB] FAIL stall_hold: pc=%h pend=%b want %h/%b", pc, slot_pending, e.pc, e.pend);
      end
    end
    stall = 0; redirect_sel = 2'b11; jr_addr = 32'h5000;
    step(32'h3014, 1'b0);
`else
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      step(32'h3000, 1'b0);
      e = sb.pop_front(); tests_run++;
      if (pc !== e.pc || slot_pending !== e.pend) begin
        failed++; $display("[TB] FAIL stall_hold: pc=%h pend=%b want %h/%b", pc, slot_pending, e.pc, e.pend);
      end
    end
    idle();
    step(32'h3004, 1'b0);
`endif
    e = sb.pop_front(); tests_run++;
    if (pc !== e.pc || slot_pending !== e.pend) begin
      failed++; $display("[TB] FAIL stall_release: pc=%h pend=%b want %h/%b", pc, slot_pending, e.pc, e.pend);
    end
    idle();
  endtask

  task automatic test_exception();
    exp_t e;
`ifdef PC_DELAY_SLOT_EN
    redirect_sel = 2'b10; j_index = 26'h0000C10;
    step(32'h3018, 1'b1);
    e = sb.pop_front(); tests_run++;
    if (pc !== e.pc || slot_pending !== e.pend) begin
      failed++; $display("[TB] FAIL exc_queue: pc=%h pend=%b want %h/%b", pc, slot_pending, e.pc, e.pend);
    end
`endif
    exc_req = 1; stall = 1; redirect_sel = 2'b01; br_taken = 1; br_imm = 16'hFFFC;
    step(32'h4180, 1'b0);
    e = sb.pop_front(); tests_run++;
    if (pc !== e.pc || slot_pending !== e.pend) begin
      failed++; $display("[TB] FAIL exc_priority: pc=%h pend=%b want %h/%b", pc, slot_pending, e.pc, e.pend);
    end
    idle();
    eret = 1; stall = 1; epc = 32'h3020;
    step(32'h3020, 1'b0);
    e = sb.pop_front(); tests_run++;
    if (pc !== e.pc) begin failed++; $display("[TB] FAIL eret: got %h want %h", pc, e.pc); end
    idle();
    step(32'h3024, 1'b0);
    e = sb.pop_front(); tests_run++;
    if (pc !== e.pc) begin failed++; $display("[TB] FAIL eret_next: got %h want %h", pc, e.pc); end
    exc_req = 1; eret = 1; epc = 32'h3020;
    step(32'h4180, 1'b0);
    e = sb.pop_front(); tests_run++;
    if (pc !== e.pc) begin failed++; $display("[TB] FAIL exc_over_eret: got %h want %h", pc, e.pc); end
    idle();
  endtask

  task automatic test_wrap();
    exp_t e;
    tests_run++;
    if (w_pc !== 28'hFFFFFFC) begin failed++; $display("[TB] FAIL wrap_reset: got %h want FFFFFFC", w_pc); end
    w_rst_n = 1;
    step(32'h0, 1'b0);
    e = sb.pop_front(); tests_run += 2;
    if ({4'h0, w_pc} !== e.pc) begin failed++; $display("[TB] FAIL wrap: got %h want %h", w_pc, e.pc); end
    if (w_pc_plus8 !== 28'h8) begin failed++; $display("[TB] FAIL wrap_plus8: got %h want 8", w_pc_plus8); end
    redirect_sel = 2'b10; j_index = 26'h3FFFFFF;
`ifdef PC_DELAY_SLOT_EN
    step(32'h4, 1'b1);
    e = sb.pop_front(); tests_run++;
    if ({4'h0, w_pc} !== e.pc || w_slot_pending !== e.pend) begin
      failed++; $display("[TB] FAIL wrap_jslot: pc=%h pend=%b want %h/%b", w_pc, w_slot_pending, e.pc, e.pend);
    end
    idle();
`endif
    step(32'h0FFFFFFC, 1'b0);
    e = sb.pop_front(); tests_run++;
    if ({4'h0, w_pc} !== e.pc || w_slot_pending !== e.pend) begin
      failed++; $display("[TB] FAIL wrap_jump: pc=%h pend=%b want %h/%b", w_pc, w_slot_pending, e.pc, e.pend);
    end
    idle();
    step(32'h0, 1'b0);
    e = sb.pop_front(); tests_run++;
    if ({4'h0, w_pc} !== e.pc) begin failed++; $display("[TB] FAIL wrap_again: got %h want %h", w_pc, e.pc); end
  endtask

  initial begin
    rst_n = 0; w_rst_n = 0;
    w_jr_addr = '0; w_epc = '0;
    idle();
    #12 rst_n = 1;
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_stall();
    test_exception();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
